// File: rtl/powlib_ipsaxi_wr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : powlib_ipsaxi_wr_pkg
//  Purpose  : Shared AXI field widths, burst/response codes and FSM encodings
//             for the powlib AXI write-slave endpoint.
//  Revision : 1.0  initial release
// ============================================================================
package powlib_ipsaxi_wr_pkg;

    localparam int c_powlib_bw   = 8;
    localparam int c_axi_lenw    = 8;
    localparam int c_axi_sizew   = 3;
    localparam int c_axi_burstw  = 2;
    localparam int c_axi_respw   = 2;

    localparam logic [c_axi_burstw-1:0] c_burst_fixed = 2'b00;
    localparam logic [c_axi_burstw-1:0] c_burst_incr  = 2'b01;
    localparam logic [c_axi_burstw-1:0] c_burst_wrap  = 2'b10;
    localparam logic [c_axi_burstw-1:0] c_burst_rsvd  = 2'b11;

    localparam logic [c_axi_respw-1:0]  c_resp_okay   = 2'b00;
    localparam logic [c_axi_respw-1:0]  c_resp_slverr = 2'b10;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_data  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    typedef struct packed {
        logic [c_axi_lenw-1:0]   len;
        logic [c_axi_sizew-1:0]  size;
        logic [c_axi_burstw-1:0] burst;
    } burst_cfg_t;

    function automatic logic wrap_len_ok(input logic [c_axi_lenw-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage
`default_nettype wire

// File: rtl/powlib_ipsaxi_wr_addrgen.sv
`default_nettype none
// ============================================================================
//  Module   : powlib_ipsaxi_wr_addrgen
//  Purpose  : Combinational next-beat byte address for FIXED/INCR/WRAP bursts.
//  Revision : 1.0  initial release
// ============================================================================
module powlib_ipsaxi_wr_addrgen
    import powlib_ipsaxi_wr_pkg::*;
#(
    parameter int B_AW = 32
) (
    input  logic [B_AW-1:0]         i_addr,
    input  logic [c_axi_sizew-1:0]  i_size,
    input  logic [c_axi_lenw-1:0]   i_len,
    input  logic [c_axi_burstw-1:0] i_burst,
    output logic [B_AW-1:0]         o_next
);

    logic [B_AW-1:0] w_step;
    logic [B_AW-1:0] w_amask;
    logic [B_AW-1:0] w_bnd;
    logic [B_AW-1:0] w_bmask;
    logic [B_AW-1:0] w_sum;

    assign w_step  = B_AW'(1) << i_size;
    assign w_amask = w_step - B_AW'(1);
    assign w_bnd   = B_AW'({1'b0, i_len} + 9'd1) << i_size;
    assign w_bmask = w_bnd - B_AW'(1);
    assign w_sum   = i_addr + w_step;

    // INCR realigns to the beat size so an unaligned start only affects beat 0
    always_comb begin
        o_next = i_addr;
        case (i_burst)
            c_burst_incr: o_next = (i_addr & ~w_amask) + w_step;
            c_burst_wrap: o_next = (i_addr & ~w_bmask) | (w_sum & w_bmask);
            default:      o_next = i_addr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/powlib_ipsaxi_wr.sv
`default_nettype none
// ============================================================================
//  Module   : powlib_ipsaxi_wr
//  Purpose  : AXI4 write-slave endpoint; expands AW/W bursts into powlib write
//             beats and returns a B response once the last beat has drained.
//  Revision : 1.0  initial release
// ============================================================================
module powlib_ipsaxi_wr
    import powlib_ipsaxi_wr_pkg::*;
#(
    parameter int          B_BPD = 4,
    parameter logic [31:0] ID    = "SAXI",
    parameter int          EDBG  = 0,
    localparam int         B_AW  = c_powlib_bw * B_BPD,
    localparam int         B_DW  = c_powlib_bw * B_BPD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [B_AW-1:0]         awaddr,
    input  logic [c_axi_lenw-1:0]   awlen,
    input  logic [c_axi_sizew-1:0]  awsize,
    input  logic [c_axi_burstw-1:0] awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [B_DW-1:0]         wdata,
    input  logic [B_BPD-1:0]        wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [c_axi_respw-1:0]  bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [B_AW-1:0]         wraddr,
    output logic [B_DW-1:0]         wrdata,
    output logic [B_BPD-1:0]        wrbe,
    output logic                    wrvld,
    input  logic                    wrrdy
);

    localparam logic [c_axi_sizew-1:0] c_size_max = c_axi_sizew'($clog2(B_BPD));

    logic [1:0]             r_state;
    logic [B_AW-1:0]        r_addr;
    burst_cfg_t             r_cfg;
    logic [c_axi_lenw-1:0]  r_cnt;
    logic                   r_err;
    logic                   r_wrvld;
    logic [B_AW-1:0]        r_wraddr;
    logic [B_DW-1:0]        r_wrdata;
    logic [B_BPD-1:0]       r_wrbe;
    logic                   r_bvalid;
    logic [c_axi_respw-1:0] r_bresp;

    logic [B_AW-1:0] w_next_addr;
    logic            w_awready;
    logic            w_wready;
    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_load;
    logic            w_last_beat;
    logic            w_drained;
    logic            w_cfg_err;
    logic            w_unused_dbg;

    // Debug-only parameters have no hardware effect
    assign w_unused_dbg = (EDBG != 0) ^ (^ID);

    powlib_ipsaxi_wr_addrgen #(
        .B_AW    (B_AW)
    ) u_addrgen (
        .i_addr  (r_addr),
        .i_size  (r_cfg.size),
        .i_len   (r_cfg.len),
        .i_burst (r_cfg.burst),
        .o_next  (w_next_addr)
    );

    assign w_awready   = (r_state == c_st_idle) && !rst;
    assign w_wready    = (r_state == c_st_data) && (!r_wrvld || wrrdy);
    assign w_aw_hs     = awvalid && w_awready;
    assign w_w_hs      = wvalid && w_wready;
    assign w_load      = w_w_hs && !r_err;
    assign w_last_beat = (r_cnt == r_cfg.len);
    assign w_drained   = !r_wrvld || wrrdy;
    assign w_cfg_err   = (awsize > c_size_max) || (awburst == c_burst_rsvd) ||
                         ((awburst == c_burst_wrap) && !wrap_len_ok(awlen));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_addr   <= '0;
            r_cfg    <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_wrvld  <= 1'b0;
            r_wraddr <= '0;
            r_wrdata <= '0;
            r_wrbe   <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= c_resp_okay;
        end else begin
            // A new beat overrides the downstream pop in the same cycle
            if (w_load) begin
                r_wrvld  <= 1'b1;
                r_wraddr <= r_addr;
                r_wrdata <= wdata;
                r_wrbe   <= wstrb;
            end else if (wrrdy) begin
                r_wrvld  <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_aw_hs) begin
                        r_addr  <= awaddr;
                        r_cfg   <= '{len: awlen, size: awsize, burst: awburst};
                        r_cnt   <= '0;
                        r_err   <= w_cfg_err;
                        r_state <= c_st_data;
                    end
                end
                c_st_data: begin
                    if (w_w_hs) begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_addr <= w_next_addr;
                        if (wlast != w_last_beat) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_beat) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (w_drained) begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= r_err ? c_resp_slverr : c_resp_okay;
                        r_state  <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    if (bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign awready = w_awready;
    assign wready  = w_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign wrvld   = r_wrvld;
    assign wraddr  = r_wraddr;
    assign wrdata  = r_wrdata;
    assign wrbe    = r_wrbe;

endmodule
`default_nettype wire

// File: tb/tb_powlib_ipsaxi_wr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_powlib_ipsaxi_wr
//  Purpose  : Directed self-checking bench with a burst-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_powlib_ipsaxi_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] wraddr;
    logic [31:0] wrdata;
    logic [3:0]  wrbe;
    logic        wrvld;
    logic        wrrdy = 1'b1;

    always #5 clk = ~clk;

    powlib_ipsaxi_wr #(.B_BPD(4), .ID("SAXI"), .EDBG(0)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .wraddr(wraddr), .wrdata(wrdata), .wrbe(wrbe), .wrvld(wrvld), .wrrdy(wrrdy)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_be[$];
    logic [1:0]  exp_resp[$];
    logic [31:0] obs_addr[$];
    int          obs_cyc[$];
    logic [31:0] beat_data[256];
    logic [3:0]  beat_strb[256];
    int          resp_seen    = 0;
    logic [1:0]  last_bresp   = 2'b00;
    int          wrvld_cycles = 0;
    int          first_w_cyc  = -1;
    int          first_wr_cyc = -1;
    int          wrrdy_mode   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: actual=timeout required=handshake (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (wrrdy_mode)
            0:       wrrdy = 1'b1;
            1:       wrrdy = ~wrrdy;
            default: wrrdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Compare process: every downstream pop and every B handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (wrvld) wrvld_cycles++;
            if (wvalid && wready && first_w_cyc < 0) first_w_cyc = cyc;
            if (wrvld && wrrdy) begin
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                obs_addr.push_back(wraddr);
                obs_cyc.push_back(cyc);
                if (exp_addr.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: actual wraddr=0x%0h required=no beat", wraddr);
                end else begin
                    chk("wraddr", wraddr, exp_addr.pop_front());
                    chk("wrdata", wrdata, exp_data.pop_front());
                    chk("wrbe", 32'(wrbe), 32'(exp_be.pop_front()));
                end
            end
            if (wrvld && !wrrdy) chk("wready_stall", 32'(wready), 32'(0));
            if (bvalid && bready) begin
                last_bresp = bresp;
                if (exp_resp.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_resp: actual bresp=%0d required=no response", bresp);
                end else begin
                    chk("bresp", 32'(bresp), 32'(exp_resp.pop_front()));
                end
                chk("beats_drained", 32'(exp_addr.size()), 32'(0));
                resp_seen++;
            end
        end
    end

    // Reference model: which beats reach downstream, at what address, and the response
    task automatic model_burst(input logic [31:0] a, input int len, input int size,
                               input logic [1:0] burst, input int bad_last);
        logic        cfg_err;
        int          nfwd;
        logic [31:0] sz;
        logic [31:0] bnd;
        logic [31:0] base;
        logic [31:0] ad;
        cfg_err = (size > 2) || (burst == 2'b11) ||
                  (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
        nfwd    = cfg_err ? 0 : ((bad_last >= 0) ? bad_last + 1 : len + 1);
        sz      = 32'(1) << size;
        bnd     = 32'(len + 1) * sz;
        for (int i = 0; i < nfwd; i++) begin
            if (burst == 2'b00) begin
                ad = a;
            end else if (burst == 2'b01) begin
                ad = (i == 0) ? a : (a / sz) * sz + 32'(i) * sz;
            end else begin
                base = a - (a % bnd);
                ad   = base + ((a % bnd) + 32'(i) * sz) % bnd;
            end
            exp_addr.push_back(ad);
            exp_data.push_back(beat_data[i]);
            exp_be.push_back(beat_strb[i]);
        end
        exp_resp.push_back((cfg_err || bad_last >= 0) ? 2'b10 : 2'b00);
    endtask

    task automatic run_burst(input logic [31:0] a, input int len, input int size,
                             input logic [1:0] burst, input int bad_last, input int bhold);
        int   beat;
        int   guard;
        int   target;
        logic hs;
        for (int i = 0; i <= len; i++) begin
            beat_data[i] = $urandom;
            beat_strb[i] = 4'($urandom);
        end
        model_burst(a, len, size, burst, bad_last);
        target       = resp_seen + 1;
        wrvld_cycles = 0;
        @(posedge clk); #1;
        awaddr = a; awlen = 8'(len); awsize = 3'(size); awburst = burst; awvalid = 1'b1;
        if (bhold > 0) bready = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!awready && guard < 50);
        if (!awready) begin
            timeout("aw_accept");
            awvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        beat = 0; wvalid = 1'b1;
        wdata = beat_data[0]; wstrb = beat_strb[0]; wlast = (len == 0) ^ (bad_last == 0);
        guard = 0;
        while (beat <= len && guard < 400) begin
            @(negedge clk);
            hs = wvalid && wready;
            guard++;
            @(posedge clk); #1;
            if (hs) begin
                beat++;
                if (beat <= len) begin
                    wdata = beat_data[beat]; wstrb = beat_strb[beat];
                    wlast = (beat == len) ^ (bad_last == beat);
                end else begin
                    wvalid = 1'b0; wlast = 1'b0;
                end
            end
        end
        if (beat <= len) begin
            timeout("w_beats");
            wvalid = 1'b0;
        end
        if (bhold > 0) begin
            guard = 0;
            do begin @(negedge clk); guard++; end while (!bvalid && guard < 50);
            if (!bvalid) timeout("bvalid_wait");
            for (int j = 0; j < bhold; j++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("bvalid_hold", 32'(bvalid), 32'(1));
            end
            @(posedge clk); #1;
            bready = 1'b1;
        end
        guard = 0;
        while (resp_seen < target && guard < 100) begin
            @(negedge clk); guard++;
        end
        if (resp_seen < target) timeout("b_resp");
        @(posedge clk); #1;
    endtask

    task automatic chk_addrs(input string name, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e[4];
        e = '{e0, e1, e2, e3};
        chk({name, "_count"}, 32'(obs_addr.size()), 32'(4));
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) chk(name, obs_addr[i], e[i]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        rst = 1'b1; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(awready), 32'(0));
        chk("rst_wready", 32'(wready), 32'(0));
        chk("rst_bvalid", 32'(bvalid), 32'(0));
        chk("rst_bresp", 32'(bresp), 32'(0));
        chk("rst_wrvld", 32'(wrvld), 32'(0));
        chk("rst_wraddr", wraddr, 32'(0));
        chk("rst_wrdata", wrdata, 32'(0));
        chk("rst_wrbe", 32'(wrbe), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // INCR, back-to-back, one-cycle latency
        obs_addr.delete(); obs_cyc.delete(); first_w_cyc = -1; first_wr_cyc = -1;
        run_burst(32'h100, 3, 2, 2'b01, -1, 0);
        chk_addrs("incr_addr", 32'h100, 32'h104, 32'h108, 32'h10C);
        chk("incr_latency", 32'(first_wr_cyc - first_w_cyc), 32'(1));
        if (obs_cyc.size() == 4) chk("incr_b2b", 32'(obs_cyc[3] - obs_cyc[0]), 32'(3));
        chk("incr_bresp", 32'(last_bresp), 32'(0));

        // WRAP across the 16-byte boundary
        obs_addr.delete();
        run_burst(32'h1C, 3, 2, 2'b10, -1, 0);
        chk_addrs("wrap_addr", 32'h1C, 32'h10, 32'h14, 32'h18);
        chk("wrap_bresp", 32'(last_bresp), 32'(0));

        // Downstream ready toggling every cycle
        wrrdy_mode = 1; obs_addr.delete();
        run_burst(32'h2000, 7, 2, 2'b01, -1, 0);
        chk("toggle_count", 32'(obs_addr.size()), 32'(8));
        wrrdy_mode = 0;

        // Oversized beat: consumed, never forwarded
        run_burst(32'h400, 3, 3, 2'b01, -1, 0);
        chk("size_err_wrvld", 32'(wrvld_cycles), 32'(0));
        chk("size_err_bresp", 32'(last_bresp), 32'(2));

        // Early wlast on beat 2: burst still runs all four beats
        run_burst(32'h500, 3, 2, 2'b01, 1, 0);
        chk("wlast_err_bresp", 32'(last_bresp), 32'(2));

        // Reset during DATA after the first beat
        @(posedge clk); #1;
        awaddr = 32'h200; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!awready && guard < 50);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'hDEAD0001; wstrb = 4'hF; wlast = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!wready && guard < 50);
        if (!wready) timeout("rst_beat1");
        @(posedge clk); #1;
        rst = 1'b1; wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_wrvld", 32'(wrvld), 32'(0));
        chk("rst_mid_bvalid", 32'(bvalid), 32'(0));
        chk("rst_mid_awready", 32'(awready), 32'(1));
        run_burst(32'h300, 1, 2, 2'b01, -1, 0);
        chk("post_rst_bresp", 32'(last_bresp), 32'(0));

        // Address-rule corners, error codes and B back-pressure
        run_burst(32'h103, 2, 2, 2'b01, -1, 0);
        run_burst(32'hFFFF_FFF8, 3, 2, 2'b01, -1, 0);
        run_burst(32'h10, 3, 0, 2'b01, -1, 0);
        run_burst(32'h40, 2, 2, 2'b00, -1, 3);
        run_burst(32'h60, 2, 2, 2'b10, -1, 0);
        run_burst(32'h80, 1, 2, 2'b11, -1, 0);
        run_burst(32'h700, 3, 2, 2'b01, 3, 0);
        wrrdy_mode = 2;
        run_burst(32'h3A, 7, 1, 2'b10, -1, 0);
        run_burst(32'h800, 15, 2, 2'b01, -1, 2);
        wrrdy_mode = 0;

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
